// File: rtl/mole_scheduler_if.sv
// Signal bundle between the whack-a-mole game side and the round scheduler.
// Game side drives start/game_end/rand_seg/hit/wrong; scheduler drives mole state,
// spawn/timeout pulses, level and miss count. master = game side, slave = scheduler.
interface mole_scheduler_if;
  logic       start;
  logic       game_end;
  logic [2:0] rand_seg;
  logic       hit;
  logic       wrong;
  logic       mole_up;
  logic [2:0] mole_seg;
  logic       spawn;
  logic       timeout;
  logic [2:0] level;
  logic [7:0] miss_cnt;

  modport master (
    output start, game_end, rand_seg, hit, wrong,
    input  mole_up, mole_seg, spawn, timeout, level, miss_cnt
  );

  modport slave (
    input  start, game_end, rand_seg, hit, wrong,
    output mole_up, mole_seg, spawn, timeout, level, miss_cnt
  );
endinterface

// File: rtl/mole_scheduler.sv
// Round scheduler: spawns moles after a fixed gap, times their window (shrinking per level), counts misses.
// Latency: every input event is reflected on the registered outputs one clock after it is sampled.
// No backpressure: hit/wrong/start are single-cycle pulses; clk/rst_n plain, everything else via sif (slave).
module mole_scheduler #(
  parameter int TICK_DIV       = 20000,
  parameter int WIN_BASE       = 1000,
  parameter int WIN_STEP       = 150,
  parameter int WIN_MIN        = 250,
  parameter int GAP_TICKS      = 200,
  parameter int HITS_PER_LEVEL = 5,
  parameter int MAX_LEVEL      = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  mole_scheduler_if.slave   sif
);

  localparam int              TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [15:0]     GAP_T     = 16'(GAP_TICKS);
  localparam logic [15:0]     W_BASE    = 16'(WIN_BASE);
  localparam logic [15:0]     W_STEP    = 16'(WIN_STEP);
  localparam logic [15:0]     W_MIN     = 16'(WIN_MIN);
  localparam logic [2:0]      LVL_MAX   = 3'(MAX_LEVEL);
  localparam logic [7:0]      HPL       = 8'(HITS_PER_LEVEL);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_UP, S_DONE} state_t;

  state_t          state_q;
  logic [TW-1:0]   tick_q;
  logic [15:0]     ev_q;
  logic [15:0]     win_q;
  logic [7:0]      hits_q;
  logic [2:0]      level_q;
  logic [7:0]      miss_q;
  logic [2:0]      seg_q;
  logic            mole_up_q;
  logic            spawn_q;
  logic            timeout_q;
  logic            blank_q;   // set for the one cycle after an accepted start

  logic            tick_wrap;
  logic            gap_done;
  logic            win_done;
  logic            end_eff;
  logic            restart;
  logic [15:0]     prod;
  logic [16:0]     diff;
  logic [15:0]     win_d;
  logic [8:0]      miss_sum;
  logic [7:0]      miss_d;
  logic [7:0]      hits_d;
  logic [2:0]      level_d;
  logic [2:0]      seg_d;

  always_comb begin
    tick_wrap = (tick_q == TICK_LAST);
    gap_done  = tick_wrap && ((ev_q + 16'd1) == GAP_T);
    win_done  = tick_wrap && ((ev_q + 16'd1) == win_q);
    // The timer may drop game_end a cycle late after a restart; mask it that cycle.
    end_eff   = sif.game_end && !blank_q;
    // In GAP/UP a simultaneous game_end beats start; IDLE/DONE always accept start.
    restart   = sif.start && ((state_q == S_IDLE) || (state_q == S_DONE) || !end_eff);

    // Window from the current level; the 17th bit catches subtraction underflow.
    prod      = 16'(level_q) * W_STEP;
    diff      = {1'b0, W_BASE} - {1'b0, prod};
    win_d     = (diff[16] || (diff[15:0] < W_MIN)) ? W_MIN : diff[15:0];

    seg_d     = (sif.rand_seg == 3'd7) ? 3'd0 : sif.rand_seg;

    // A wrong press and an unhit expiry in the same cycle both count.
    miss_sum  = {1'b0, miss_q} + 9'(sif.wrong) + 9'(win_done && !sif.hit);
    miss_d    = miss_sum[8] ? 8'hFF : miss_sum[7:0];

    hits_d    = hits_q + 8'd1;
    level_d   = level_q;
    if (hits_d >= HPL) begin
      hits_d = 8'd0;
      if (level_q < LVL_MAX) level_d = level_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      ev_q      <= '0;
      win_q     <= '0;
      hits_q    <= '0;
      level_q   <= '0;
      miss_q    <= '0;
      seg_q     <= '0;
      mole_up_q <= 1'b0;
      spawn_q   <= 1'b0;
      timeout_q <= 1'b0;
      blank_q   <= 1'b0;
    end else begin
      spawn_q   <= 1'b0;
      timeout_q <= 1'b0;
      blank_q   <= 1'b0;
      if (tick_wrap) begin
        tick_q <= '0;
        ev_q   <= ev_q + 16'd1;
      end else begin
        tick_q <= tick_q + TW'(1);
      end

      if (restart) begin
        state_q   <= S_GAP;
        level_q   <= '0;
        miss_q    <= '0;
        hits_q    <= '0;
        mole_up_q <= 1'b0;
        tick_q    <= '0;
        ev_q      <= '0;
        blank_q   <= 1'b1;
      end else begin
        case (state_q)
          S_GAP: begin
            if (end_eff) begin
              state_q <= S_DONE;
              tick_q  <= '0;
              ev_q    <= '0;
            end else if (gap_done) begin
              state_q   <= S_UP;
              tick_q    <= '0;
              ev_q      <= '0;
              seg_q     <= seg_d;
              mole_up_q <= 1'b1;
              spawn_q   <= 1'b1;
              win_q     <= win_d;
            end
          end
          S_UP: begin
            if (end_eff) begin
              state_q   <= S_DONE;
              mole_up_q <= 1'b0;
              tick_q    <= '0;
              ev_q      <= '0;
            end else begin
              miss_q <= miss_d;
              if (sif.hit) begin
                state_q   <= S_GAP;
                mole_up_q <= 1'b0;
                hits_q    <= hits_d;
                level_q   <= level_d;
                tick_q    <= '0;
                ev_q      <= '0;
              end else if (win_done) begin
                state_q   <= S_GAP;
                mole_up_q <= 1'b0;
                timeout_q <= 1'b1;
                tick_q    <= '0;
                ev_q      <= '0;
              end
            end
          end
          default: begin
            // IDLE/DONE: counters parked until the next start.
            tick_q <= '0;
            ev_q   <= '0;
          end
        endcase
      end
    end
  end

  assign sif.mole_up  = mole_up_q;
  assign sif.mole_seg = seg_q;
  assign sif.spawn    = spawn_q;
  assign sif.timeout  = timeout_q;
  assign sif.level    = level_q;
  assign sif.miss_cnt = miss_q;

endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Round scheduler for the whack-a-mole core: decides when a mole appears, which segment it occupies, and how long it stays up. Window length shrinks as the player advances through difficulty levels. It sits between the RNG and game timer on one side and the game FSM / seg7 driver on the other. It consumes the FSM's hit/wrong-press pulses and issues spawn and timeout events plus a miss count.

## Interface
Parameters:
- TICK_DIV, 20000, clk cycles per scheduler tick (1 ms at 20 MHz)
- WIN_BASE, 1000, mole window at level 0, in ticks
- WIN_STEP, 150, window reduction per level, in ticks
- WIN_MIN, 250, window floor, in ticks
- GAP_TICKS, 200, blank time between moles, in ticks
- HITS_PER_LEVEL, 5, correct hits needed to advance one level
- MAX_LEVEL, 7, level saturation value

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle restart pulse (edge-detected pb0)
- game_end  in  1  level signal from game timer
- rand_seg  in  3  LFSR segment candidate
- hit  in  1  one-cycle correct-hit pulse; ignored unless mole_up
- wrong  in  1  one-cycle wrong-press pulse; ignored unless mole_up
- mole_up  out  1  mole currently displayed
- mole_seg  out  3  active segment, 0..6
- spawn  out  1  one-cycle pulse on mole appearance
- timeout  out  1  one-cycle pulse when a mole expires unhit
- level  out  3  current difficulty level
- miss_cnt  out  8  timeouts plus wrong presses, saturating

## Operation
- States: IDLE, GAP, UP, DONE.
- The reset state is IDLE. Every output resets to 0.
- All outputs are registered.
- Internal counters:
  - tick_cnt counts 0..TICK_DIV-1.
  - ev_cnt counts ticks.
  - hit_in_level counts hits at the current level.
- tick_cnt and ev_cnt clear on every state transition.
- Window: window = WIN_BASE − level×WIN_STEP, computed 16-bit. If that value is below WIN_MIN, or the subtraction underflows, window = WIN_MIN. Window is evaluated at UP entry.
- IDLE:
  - mole_up = 0.
  - start → GAP; clear level, miss_cnt and hit_in_level.
- GAP:
  - Lasts exactly GAP_TICKS×TICK_DIV cycles.
  - On expiry, go to UP. mole_seg latches rand_seg, with 7 mapped to 0. Set mole_up = 1 and pulse spawn.
- UP, priority order:
  1. game_end → DONE.
  2. hit → GAP; mole_up = 0; hit_in_level++. When hit_in_level reaches HITS_PER_LEVEL, it clears to 0 and level increments if level < MAX_LEVEL (otherwise level holds).
  3. Window elapsed (mole_up high exactly window×TICK_DIV cycles) → GAP; pulse timeout; miss_cnt++.
- wrong in UP:
  - miss_cnt++ and the state is unchanged.
  - wrong in the same cycle as a timeout gives miss_cnt += 2.
  - wrong in the same cycle as a hit is still counted.
- hit and window expiry in the same cycle: the hit wins and timeout is not pulsed.
- miss_cnt saturates at 255.
- GAP: game_end → DONE.
- start in GAP or UP (without game_end) restarts: clear level, miss_cnt and hit_in_level; mole_up = 0; go to GAP.
- DONE:
  - mole_up = 0; level and miss_cnt are held.
  - start → GAP with the same clears as IDLE.
- Restart blanking: game_end is ignored in the cycle following any accepted start. This covers the timer clearing game_end one cycle late.
- rst_n low at any edge, including mid-round, forces IDLE and all outputs to 0.

## Timing
- An event sampled in cycle N is visible on outputs after edge N+1.
- spawn is coincident with the first cycle of mole_up = 1.
- timeout is high in the first cycle with mole_up = 0.
- Hit response: hit in cycle N gives mole_up low from N+1. The next spawn occurs GAP_TICKS×TICK_DIV cycles after mole_up falls.
- level and miss_cnt update on the same edge as the triggering event.
- start in IDLE at cycle N gives GAP from N+1. spawn asserts at N+1+GAP_TICKS×TICK_DIV.

## Test plan
Parameters for all scenarios: TICK_DIV=4, WIN_BASE=10, WIN_STEP=3, WIN_MIN=4, GAP_TICKS=2, HITS_PER_LEVEL=2, MAX_LEVEL=7.

- Reset and no-hit round:
  - Stimulus: reset, then start with rand_seg=3 and no hits.
  - Required: all outputs 0 after reset. spawn 8 cycles after GAP entry; mole_seg=3; mole_up high 40 cycles; then timeout pulse and miss_cnt=1.
- Level ramp:
  - Stimulus: hit each mole on its 2nd UP cycle.
  - Required: after 2 hits level=1 and the next window is 28 cycles. After 4 hits level=2 with window 16 cycles; after 6 hits level=3 with window 16 cycles (floor, since 10−9 < 4).
- Simultaneous events:
  - hit and window expiry in the same cycle → level/hit counted, no timeout.
  - wrong and timeout in the same cycle → miss_cnt += 2.
  - 300 wrong pulses → miss_cnt=255.
- Segment map:
  - Stimulus: rand_seg=7 at GAP expiry.
  - Required: mole_seg=0.
- Game end and restart:
  - Stimulus: game_end mid-UP; then start while game_end is still high for 1 cycle.
  - Required: DONE with mole_up=0 and level/miss held. Restart → GAP with level=0, miss_cnt=0, no fall back to DONE.
- Reset mid-round:
  - Stimulus: rst_n low during UP for 1 cycle.
  - Required: next edge shows IDLE, all outputs 0, and no spawn until start.
